// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller, up to 8 request sources.
//
// Each source is latched into PEND either as a level (PEND follows src) or
// as a rising edge (sticky until cleared by software). PEND is masked by
// ENABLE to form the set of active sources. The single registered irq line
// is the OR of the active sources. The VECTOR register reports the
// lowest-numbered active source.
//
// Register map (addr):
//   0 PEND    read pending bits; write 1s to clear edge-mode bits
//   1 ENABLE  read/write per-source mask
//   2 MODE    read/write, 1 = edge, 0 = level
//   3 VECTOR  read {any_active, 4'b0, index}; write 1s to set edge-mode bits
//
// Ports:
//   clk   main clock
//   rst   asynchronous, active-low reset
//   dbr   read data, registered (valid the cycle after addr is presented)
//   dbw   write data
//   addr  register select
//   we    write strobe (already qualified by the system decoder)
//   src   interrupt request lines, synchronous to clk, active-high
//   irq   interrupt request to the CPU, registered, active-high
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int          NSRC     = 4,
    parameter logic [7:0]  MODE_RST = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    output logic [7:0]      dbr,
    input  logic [7:0]      dbw,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    // Bits at and above NSRC are held at zero everywhere.
    localparam logic [7:0] VALID_MASK = 8'((9'h1 << NSRC) - 9'h1);

    logic [7:0] pend_reg;
    logic [7:0] pend_next;
    logic [7:0] enable_reg;
    logic [7:0] mode_reg;
    logic [7:0] src_q_reg;
    logic [7:0] src_ext;
    logic [7:0] dbr_reg;
    logic [7:0] dbr_next;
    logic       irq_reg;

    logic [7:0] active;
    logic [2:0] vec_idx;
    logic [7:0] vector;

    logic wr_pend;
    logic wr_enable;
    logic wr_mode;
    logic wr_vector;

    assign wr_pend   = we && (addr == 2'd0);
    assign wr_enable = we && (addr == 2'd1);
    assign wr_mode   = we && (addr == 2'd2);
    assign wr_vector = we && (addr == 2'd3);

    // Per-source latch logic. In edge mode a set (hardware edge or software
    // trigger) wins over a simultaneous W1C so no edge is ever lost.
    for (genvar gi = 0; gi < 8; gi++) begin : g_src
        if (gi < NSRC) begin : g_used
            logic rise;
            logic set_bit;
            logic clr_bit;

            assign src_ext[gi]   = src[gi];
            assign rise          = src[gi] & ~src_q_reg[gi];
            assign set_bit       = rise | (wr_vector & dbw[gi]);
            assign clr_bit       = wr_pend & dbw[gi];
            assign pend_next[gi] = mode_reg[gi]
                                   ? (set_bit | (~clr_bit & pend_reg[gi]))
                                   : src[gi];
        end else begin : g_unused
            assign src_ext[gi]   = 1'b0;
            assign pend_next[gi] = 1'b0;
        end
    end

    assign active = pend_reg & enable_reg;

    // Priority encoder: scanning downward leaves the lowest active index.
    always_comb begin
        vec_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                vec_idx = 3'(i);
            end
        end
    end

    assign vector = {|active, 4'b0000, vec_idx};

    // Read mux is sampled every cycle regardless of we, so a read that
    // coincides with a write returns the pre-write contents.
    always_comb begin
        dbr_next = 8'h00;
        case (addr)
            2'd0:    dbr_next = pend_reg;
            2'd1:    dbr_next = enable_reg;
            2'd2:    dbr_next = mode_reg;
            default: dbr_next = vector;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg   <= 8'h00;
            enable_reg <= 8'h00;
            mode_reg   <= MODE_RST & VALID_MASK;
            src_q_reg  <= 8'h00;
            dbr_reg    <= 8'h00;
            irq_reg    <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            src_q_reg <= src_ext;
            dbr_reg   <= dbr_next;
            irq_reg   <= |active;
            if (wr_enable) begin
                enable_reg <= dbw & VALID_MASK;
            end
            if (wr_mode) begin
                mode_reg <= dbw & VALID_MASK;
            end
        end
    end

    assign dbr = dbr_reg;
    assign irq = irq_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl -- directed self-checking bench for irq_ctrl (NSRC=4,
// MODE_RST=8'h01). Inputs change 1 time unit after a rising edge; outputs
// are checked at the same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int         NSRC     = 4;
    localparam logic [7:0] MODE_RST = 8'h01;

    logic            clk;
    logic            rst;
    logic [7:0]      dbr;
    logic [7:0]      dbw;
    logic [1:0]      addr;
    logic            we;
    logic [NSRC-1:0] src;
    logic            irq;

    int n_cmp;
    int n_err;

    irq_ctrl #(
        .NSRC     (NSRC),
        .MODE_RST (MODE_RST)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dbr  (dbr),
        .dbw  (dbw),
        .addr (addr),
        .we   (we),
        .src  (src),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
        $display("check %-22s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
        $display("check %-22s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    // One-cycle register write; the register updates on the edge taken here.
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        dbw  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        dbw  = 8'h00;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        dbw   = 8'h00;
        src   = '0;

        // ---- 1. reset ----
        repeat (3) tick();
        chk1("rst_irq_held", irq, 1'b0);
        chk8("rst_dbr_held", dbr, 8'h00);
        rst = 1'b1;
        addr = 2'd0; tick(); chk8("rst_pend", dbr, 8'h00);
        addr = 2'd1; tick(); chk8("rst_enable", dbr, 8'h00);
        addr = 2'd2; tick(); chk8("rst_mode", dbr, MODE_RST);
        addr = 2'd3; tick(); chk8("rst_vector", dbr, 8'h00);
        chk1("rst_irq", irq, 1'b0);

        // ---- 2. edge latch and clear ----
        wr(2'd2, 8'h01);
        wr(2'd1, 8'h01);
        addr = 2'd0;
        src  = 4'b0001;
        tick();                          // edge k: PEND[0] set
        src  = 4'b0000;
        chk1("edge_irq_k", irq, 1'b0);
        tick();                          // edge k+1
        chk1("edge_irq_k1", irq, 1'b1);
        chk8("edge_pend", dbr, 8'h01);
        addr = 2'd3;
        tick();
        chk8("edge_vector", dbr, 8'h80);
        wr(2'd0, 8'h01);                 // W1C clears PEND at this edge
        chk1("w1c_irq_same", irq, 1'b1);
        tick();
        chk1("w1c_irq_next", irq, 1'b0);

        // ---- 3. simultaneous edge and W1C ----
        src = 4'b0001;
        tick();
        src = 4'b0000;
        tick();
        chk1("sim_pre_irq", irq, 1'b1);
        src  = 4'b0001;
        addr = 2'd0;
        dbw  = 8'h01;
        we   = 1'b1;
        tick();                          // rise and W1C on the same edge
        we   = 1'b0;
        dbw  = 8'h00;
        src  = 4'b0000;
        tick();
        chk1("sim_irq", irq, 1'b1);
        chk8("sim_pend", dbr, 8'h01);
        wr(2'd0, 8'h01);
        tick();
        chk1("sim_clr_irq", irq, 1'b0);

        // ---- 4. level mode and priority ----
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h0F);
        src  = 4'b1010;
        tick();                          // PEND = 0A
        addr = 2'd3;
        tick();
        chk8("lvl_vector_81", dbr, 8'h81);
        chk1("lvl_irq", irq, 1'b1);
        wr(2'd0, 8'h0A);                 // no effect in level mode
        addr = 2'd0;
        tick();
        chk8("lvl_w1c_pend", dbr, 8'h0A);
        src  = 4'b1000;
        tick();                          // PEND = 08
        addr = 2'd3;
        tick();
        chk8("lvl_vector_83", dbr, 8'h83);
        src  = 4'b0000;
        tick();                          // PEND = 00
        chk1("lvl_irq_lag", irq, 1'b1);
        tick();
        chk1("lvl_irq_low", irq, 1'b0);

        // ---- 5. masking and software trigger ----
        wr(2'd2, 8'h0F);
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h04);                 // software set PEND[2]
        addr = 2'd0;
        tick();
        chk8("sw_pend", dbr, 8'h04);
        chk1("sw_irq_masked", irq, 1'b0);
        wr(2'd1, 8'h04);
        chk1("en_irq_same", irq, 1'b0);
        tick();
        chk1("en_irq_next", irq, 1'b1);
        addr = 2'd3;
        tick();
        chk8("en_vector", dbr, 8'h82);

        // ---- 6. async reset mid-operation ----
        wr(2'd1, 8'h05);
        wr(2'd3, 8'h01);                 // PEND = 05
        addr = 2'd0;
        tick();
        chk8("pre_rst_pend", dbr, 8'h05);
        chk1("pre_rst_irq", irq, 1'b1);
        src = 4'b0001;
        tick();
        #2;
        rst = 1'b0;                      // mid-cycle, no clock edge
        #1;
        chk1("async_irq", irq, 1'b0);
        chk8("async_dbr", dbr, 8'h00);
        @(negedge clk);
        rst = 1'b1;                      // src[0] still high, MODE back to 01
        tick();                          // history was 0: edge on src[0]
        chk8("post_rst_pend_old", dbr, 8'h00);
        chk1("post_rst_irq", irq, 1'b0);
        tick();
        chk8("post_rst_pend", dbr, 8'h01);
        chk1("post_rst_irq_mask", irq, 1'b0);
        wr(2'd0, 8'h01);                 // clear; src held high -> no new edge
        tick();
        chk8("held_no_edge", dbr, 8'h00);
        addr = 2'd2;
        tick();
        chk8("post_rst_mode", dbr, MODE_RST);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
